// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one mux2to1 slave between NUM_REQ requesters.
// Grants one request at a time, drives the shared mux, and returns the captured result with its requester id.
//
// state | meaning
// IDLE  | pick a winner by round-robin; o_req_ready is one-hot on the winner
// DRIVE | accepted operands are on o_mux_*; capture i_mux_y next edge
// RESP  | hold o_rsp_valid/data/id until i_rsp_ready
module mux_rr_arbiter #(
    parameter int DATA_WITH = 8,
    parameter int NUM_REQ   = 4,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    output logic [NUM_REQ-1:0]             o_req_ready,
    input  logic [NUM_REQ*DATA_WITH-1:0]   i_req_a,
    input  logic [NUM_REQ*DATA_WITH-1:0]   i_req_b,
    input  logic [NUM_REQ-1:0]             i_req_sel,
    output logic [DATA_WITH-1:0]           o_mux_a,
    output logic [DATA_WITH-1:0]           o_mux_b,
    output logic                           o_mux_sel,
    input  logic [DATA_WITH-1:0]           i_mux_y,
    output logic                           o_rsp_valid,
    input  logic                           i_rsp_ready,
    output logic [DATA_WITH-1:0]           o_rsp_data,
    output logic [ID_W-1:0]                o_rsp_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] ptr_nxt;
    logic            found;
    logic            accept;

    // Scan from the pointer upward, wrapping, and take the first valid requester.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!found && i_req_valid[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    always_comb begin
        if (winner == ID_W'(NUM_REQ - 1)) begin
            ptr_nxt = '0;
        end else begin
            ptr_nxt = winner + ID_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = DRIVE;
            DRIVE:   state_nxt = RESP;
            RESP:    if (i_rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ready is gated by reset so nothing can be accepted while reset is held.
    always_comb begin
        accept      = 1'b0;
        o_req_ready = '0;
        if (state == IDLE && found && !i_rst) begin
            accept      = 1'b1;
            o_req_ready = NUM_REQ'(1) << winner;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_ptr      <= '0;
            grant_id    <= '0;
            o_mux_a     <= '0;
            o_mux_b     <= '0;
            o_mux_sel   <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_rsp_id    <= '0;
        end else begin
            if (accept) begin
                o_mux_a   <= i_req_a[int'(winner)*DATA_WITH +: DATA_WITH];
                o_mux_b   <= i_req_b[int'(winner)*DATA_WITH +: DATA_WITH];
                o_mux_sel <= i_req_sel[winner];
                grant_id  <= winner;
                rr_ptr    <= ptr_nxt;
            end
            if (state == DRIVE) begin
                o_rsp_data  <= i_mux_y;
                o_rsp_id    <= grant_id;
                o_rsp_valid <= 1'b1;
            end else if (state == RESP && i_rsp_ready) begin
                o_rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with a behavioural mux2to1 slave attached.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns after that.
module tb_mux_rr_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int IW = 2;

    logic              i_clk;
    logic              i_rst;
    logic [NR-1:0]     i_req_valid;
    logic [NR-1:0]     o_req_ready;
    logic [NR*DW-1:0]  i_req_a;
    logic [NR*DW-1:0]  i_req_b;
    logic [NR-1:0]     i_req_sel;
    logic [DW-1:0]     o_mux_a;
    logic [DW-1:0]     o_mux_b;
    logic              o_mux_sel;
    logic [DW-1:0]     i_mux_y;
    logic              o_rsp_valid;
    logic              i_rsp_ready;
    logic [DW-1:0]     o_rsp_data;
    logic [IW-1:0]     o_rsp_id;

    int n_checks;
    int n_errors;

    mux_rr_arbiter #(.DATA_WITH(DW), .NUM_REQ(NR)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_a     (i_req_a),
        .i_req_b     (i_req_b),
        .i_req_sel   (i_req_sel),
        .o_mux_a     (o_mux_a),
        .o_mux_b     (o_mux_b),
        .o_mux_sel   (o_mux_sel),
        .i_mux_y     (i_mux_y),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_data  (o_rsp_data),
        .o_rsp_id    (o_rsp_id)
    );

    assign i_mux_y = o_mux_sel ? o_mux_b : o_mux_a;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Expected result for the fixed operand set used by the multi-requester tests.
    function automatic logic [31:0] exp_data(input int k);
        return (k % 2 == 1) ? 32'(8'h20 + k) : 32'(8'h10 + k);
    endfunction

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        i_rst       = 1'b1;
        i_req_valid = '0;
        i_req_a     = '0;
        i_req_b     = '0;
        i_req_sel   = '0;
        i_rsp_ready = 1'b1;
        #1;
        check("rst_rsp_valid", 32'(o_rsp_valid), 32'h0);
        check("rst_req_ready", 32'(o_req_ready), 32'h0);
        check("rst_mux_a",     32'(o_mux_a),     32'h0);
        check("rst_rsp_id",    32'(o_rsp_id),    32'h0);
        tick();
        i_rst = 1'b0;
        #1;

        // Single requester 1, sel=1 then sel=0
        for (int pass = 0; pass < 2; pass++) begin
            i_req_a[1*DW +: DW] = 8'h3C;
            i_req_b[1*DW +: DW] = 8'hA5;
            i_req_sel[1]        = (pass == 0);
            i_req_valid         = 4'b0010;
            #1;
            check("single_ready", 32'(o_req_ready), 32'h2);
            tick();
            i_req_valid = '0;
            #1;
            check("single_drive_ready", 32'(o_req_ready), 32'h0);
            check("single_drive_valid", 32'(o_rsp_valid), 32'h0);
            tick();
            check("single_valid", 32'(o_rsp_valid), 32'h1);
            check("single_data",  32'(o_rsp_data), (pass == 0) ? 32'hA5 : 32'h3C);
            check("single_id",    32'(o_rsp_id),   32'h1);
            tick();
            check("single_done", 32'(o_rsp_valid), 32'h0);
        end

        // Reset asserted while holding a response
        i_rsp_ready = 1'b0;
        i_req_valid = 4'b0010;
        tick();
        i_req_valid = 4'b0010;
        tick();
        tick();
        check("pre_rst_valid", 32'(o_rsp_valid), 32'h1);
        i_rst = 1'b1;
        #1;
        check("midrst_rsp_valid", 32'(o_rsp_valid), 32'h0);
        check("midrst_req_ready", 32'(o_req_ready), 32'h0);
        check("midrst_mux_a",     32'(o_mux_a),     32'h0);
        check("midrst_mux_b",     32'(o_mux_b),     32'h0);
        check("midrst_mux_sel",   32'(o_mux_sel),   32'h0);
        check("midrst_rsp_data",  32'(o_rsp_data),  32'h0);
        tick();
        i_rst       = 1'b0;
        i_req_valid = '0;
        i_rsp_ready = 1'b1;
        #1;

        // All four valid: grants rotate 0,1,2,3 three times
        for (int k = 0; k < NR; k++) begin
            i_req_a[k*DW +: DW] = 8'(8'h10 + k);
            i_req_b[k*DW +: DW] = 8'(8'h20 + k);
            i_req_sel[k]        = (k % 2 == 1);
        end
        i_req_valid = 4'b1111;
        #1;
        for (int t = 0; t < 12; t++) begin
            check("rr_ready", 32'(o_req_ready), 32'(1) << (t % NR));
            tick();
            tick();
            check("rr_valid", 32'(o_rsp_valid), 32'h1);
            check("rr_id",    32'(o_rsp_id),    32'(t % NR));
            check("rr_data",  32'(o_rsp_data),  exp_data(t % NR));
            tick();
        end

        // Backpressure with requesters 0 and 2 pending
        i_rsp_ready = 1'b0;
        i_req_valid = 4'b0101;
        #1;
        check("bp_ready", 32'(o_req_ready), 32'h1);
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            check("bp_valid",     32'(o_rsp_valid), 32'h1);
            check("bp_data",      32'(o_rsp_data),  exp_data(0));
            check("bp_id",        32'(o_rsp_id),    32'h0);
            check("bp_req_ready", 32'(o_req_ready), 32'h0);
            tick();
        end
        i_rsp_ready = 1'b1;
        #1;
        tick();
        check("bp_released",   32'(o_rsp_valid), 32'h0);
        check("bp_next_grant", 32'(o_req_ready), 32'h4);

        // Pointer: after granting 2, requester 3 wins over 0
        tick();
        i_req_valid = 4'b1001;
        tick();
        check("ptr_id2", 32'(o_rsp_id), 32'h2);
        tick();
        check("ptr_ready3", 32'(o_req_ready), 32'h8);
        tick();
        tick();
        check("ptr_id3",   32'(o_rsp_id),   32'h3);
        check("ptr_data3", 32'(o_rsp_data), exp_data(3));
        tick();
        check("ptr_ready0", 32'(o_req_ready), 32'h1);

        // Operands changed after accept must not affect the result
        i_req_valid       = 4'b0001;
        i_req_a[0 +: DW]  = 8'h11;
        i_req_b[0 +: DW]  = 8'h22;
        i_req_sel[0]      = 1'b1;
        tick();
        i_req_valid       = '0;
        i_req_a[0 +: DW]  = 8'hAA;
        i_req_b[0 +: DW]  = 8'hFF;
        i_req_sel[0]      = 1'b0;
        #1;
        check("hold_mux_b",   32'(o_mux_b),   32'h22);
        check("hold_mux_sel", 32'(o_mux_sel), 32'h1);
        tick();
        check("hold_data", 32'(o_rsp_data), 32'h22);
        check("hold_id",   32'(o_rsp_id),   32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
